ps2_rx: RTL and testbench

- Receives PS/2 keyboard frames on the raw ps2_clk/ps2_data pins and delivers each received scan-code byte.
- Output is an 8-bit scancode with a one-cycle flag strobe.
- Sits directly upstream of the colour-control stage, which consumes scancode/flag.
- Handles synchronisation, clock-glitch filtering, frame checking and receive timeout.

---
 rtl/ps2_defs.sv | 31 +++
 rtl/ps2_clk_filter.sv | 52 +++++
 rtl/ps2_rx.sv | 170 +++++++++++++++++
 tb/tb_ps2_rx.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_defs.sv
// ============================================================================
// Module   : ps2_defs (package)
// Purpose  : Shared PS/2 receiver constants: FSM encodings, special codes.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ps2_defs;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_DATA   = 2'd1;
    localparam logic [1:0] c_ST_PARITY = 2'd2;
    localparam logic [1:0] c_ST_STOP   = 2'd3;

    localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
    localparam logic [7:0] PS2_EXT_CODE   = 8'hE0;

    // start + 8 data + parity + stop
    localparam int PS2_FRAME_BITS = 11;

    function automatic logic is_break_code(input logic [7:0] code);
        return code == PS2_BREAK_CODE;
    endfunction

    function automatic logic is_ext_code(input logic [7:0] code);
        return code == PS2_EXT_CODE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_clk_filter.sv
// ============================================================================
// Module   : ps2_clk_filter
// Purpose  : 2-flop synchroniser, FILTER_LEN-sample level filter and falling
//            edge detector for the raw PS/2 clock pin.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic i_ps2_clk,
    output logic o_fall
);

    localparam int              c_CW       = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(FILTER_LEN - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);

    logic [1:0]      r_sync;
    logic            r_filt;
    logic            r_filt_q;
    logic [c_CW-1:0] r_cnt;

    // r_cnt counts consecutive samples that disagree with the filtered level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync   <= 2'b11;
            r_filt   <= 1'b1;
            r_filt_q <= 1'b1;
            r_cnt    <= '0;
        end else begin
            r_sync   <= {r_sync[0], i_ps2_clk};
            r_filt_q <= r_filt;
            if (r_sync[1] == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_filt <= r_sync[1];
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end
    end

    assign o_fall = r_filt_q & ~r_filt;

endmodule

`default_nettype wire

// File: rtl/ps2_rx.sv
// ============================================================================
// Module   : ps2_rx
// Purpose  : PS/2 keyboard frame receiver delivering scan-code bytes with a
//            one-cycle flag; optional break-code suppression via the macro
//            PS2_BREAK_FILTER_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ps2_rx
    import ps2_defs::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scancode,
    output logic       flag,
    output logic       frame_err
);

    localparam int              c_TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TW-1:0] c_TO_LAST  = c_TW'(TIMEOUT_CYCLES - 1);
    localparam logic [c_TW-1:0] c_TO_ONE   = c_TW'(1);
    localparam logic [2:0]      c_LAST_BIT = 3'(PS2_FRAME_BITS - 4);

    logic [1:0]      r_state;
    logic [1:0]      w_next;
    logic [1:0]      r_dsync;
    logic [7:0]      r_shift;
    logic [2:0]      r_bitcnt;
    logic            r_parity;
    logic [c_TW-1:0] r_tocnt;
    logic [7:0]      r_scancode;
    logic            r_flag;
    logic            r_frame_err;

    logic w_fall;
    logic w_data;
    logic w_timeout;
    logic w_start;
    logic w_shift_en;
    logic w_cap_par;
    logic w_accept;
    logic w_err;
    logic w_deliver;

    ps2_clk_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .clk       (clk),
        .reset     (reset),
        .i_ps2_clk (ps2_clk),
        .o_fall    (w_fall)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dsync <= 2'b11;
        end else begin
            r_dsync <= {r_dsync[0], ps2_data};
        end
    end

    assign w_data    = r_dsync[1];
    // Timeout wins over a coincident fall, which is then ignored.
    assign w_timeout = (r_state != c_ST_IDLE) && (r_tocnt == c_TO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_timeout) begin
            w_next = c_ST_IDLE;
        end else if (w_fall) begin
            case (r_state)
                c_ST_IDLE:   if (!w_data) w_next = c_ST_DATA;
                c_ST_DATA:   if (r_bitcnt == c_LAST_BIT) w_next = c_ST_PARITY;
                c_ST_PARITY: w_next = c_ST_STOP;
                c_ST_STOP:   w_next = c_ST_IDLE;
                default:     w_next = c_ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_start    = 1'b0;
        w_shift_en = 1'b0;
        w_cap_par  = 1'b0;
        w_accept   = 1'b0;
        w_err      = 1'b0;
        if (w_timeout) begin
            w_err = 1'b1;
        end else if (w_fall) begin
            case (r_state)
                c_ST_IDLE:   w_start    = ~w_data;
                c_ST_DATA:   w_shift_en = 1'b1;
                c_ST_PARITY: w_cap_par  = 1'b1;
                c_ST_STOP: begin
                    if ((^{r_shift, r_parity}) && w_data) w_accept = 1'b1;
                    else                                 w_err    = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef PS2_BREAK_FILTER_EN
    logic r_break;

    // F0 arms suppression of the following byte; any frame error disarms it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_break <= 1'b0;
        end else if (w_err) begin
            r_break <= 1'b0;
        end else if (w_accept) begin
            r_break <= ~r_break && is_break_code(r_shift);
        end
    end

    assign w_deliver = w_accept && !r_break && !is_break_code(r_shift);
`else
    assign w_deliver = w_accept;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift     <= 8'h00;
            r_bitcnt    <= 3'd0;
            r_parity    <= 1'b0;
            r_tocnt     <= '0;
            r_scancode  <= 8'h00;
            r_flag      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_flag      <= w_deliver;
            r_frame_err <= w_err;
            if (w_deliver) r_scancode <= r_shift;

            if (r_state == c_ST_IDLE || w_fall || w_timeout) r_tocnt <= '0;
            else                                             r_tocnt <= r_tocnt + c_TO_ONE;

            if (w_start || w_timeout) begin
                r_shift  <= 8'h00;
                r_bitcnt <= 3'd0;
            end else if (w_shift_en) begin
                r_shift  <= {w_data, r_shift[7:1]};
                r_bitcnt <= r_bitcnt + 3'd1;
            end
            if (w_cap_par) r_parity <= w_data;
        end
    end

    assign scancode  = r_scancode;
    assign flag      = r_flag;
    assign frame_err = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_ps2_rx.sv
// ============================================================================
// Module   : tb_ps2_rx
// Purpose  : Self-checking bench for ps2_rx: directed table, corner-case
//            sequences and randomized frames against a frame-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ps2_rx;

    localparam int F    = 8;
    localparam int TO   = 400;
    localparam int HALF = 40;

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] scancode;
    logic       flag;
    logic       frame_err;

    ps2_rx #(
        .FILTER_LEN     (F),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .scancode  (scancode),
        .flag      (flag),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_flag = 0, n_err = 0, n_both = 0;
    int last_flag_cyc = 0, last_fall_cyc = 0;
    logic [7:0] codes[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (flag) begin
                n_flag++;
                codes.push_back(scancode);
                last_flag_cyc = cyc;
            end
            if (frame_err) n_err++;
            if (flag && frame_err) n_both++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        last_fall_cyc = cyc;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(stop);
        ps2_data = 1'b1;
    endtask

    function automatic logic good_par(input logic [7:0] d);
        return ($countones(d) % 2) == 0;
    endfunction

    task automatic pulse_reset();
        reset = 1'b1;
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(3);
    endtask

    typedef struct {
        logic [7:0] d;
        logic       par;
        logic       stop;
        int         eflag;
        int         eerr;
        logic [7:0] ecode;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int f0, e0, q0;
        logic [7:0] exp3[3];
        logic [7:0] d, mcode;
        logic par, stop, valid, pend;
        int ef, ee;

        tbl[0] = '{8'h2D, 1'b1, 1'b1, 1, 0, 8'h2D};
        tbl[1] = '{8'h34, 1'b1, 1'b1, 0, 1, 8'h2D};
        tbl[2] = '{8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C};
        tbl[3] = '{8'h1C, 1'b0, 1'b0, 0, 1, 8'h1C};
        tbl[4] = '{8'hE0, 1'b0, 1'b1, 1, 0, 8'hE0};
        tbl[5] = '{8'h00, 1'b1, 1'b1, 1, 0, 8'h00};
        tbl[6] = '{8'h5A, 1'b0, 1'b1, 0, 1, 8'h00};
        tbl[7] = '{8'hFF, 1'b1, 1'b1, 1, 0, 8'hFF};

        #1 reset = 1'b1;
        wait_cyc(3);
        chk("reset_scancode", int'(scancode), 0);
        chk("reset_flag", int'(flag), 0);
        chk("reset_frame_err", int'(frame_err), 0);
        reset = 1'b0;
        wait_cyc(5);

        for (int i = 0; i < 8; i++) begin
            f0 = n_flag; e0 = n_err;
            send_frame(tbl[i].d, tbl[i].par, tbl[i].stop);
            wait_cyc(5);
            chk("table_flag", n_flag - f0, tbl[i].eflag);
            chk("table_err", n_err - e0, tbl[i].eerr);
            chk("table_code", int'(scancode), int'(tbl[i].ecode));
        end

        send_frame(8'h2D, 1'b1, 1'b1);
        chk("latency", last_flag_cyc - last_fall_cyc, F + 3);

        // Break sequence F0, 2D, 32 sent back to back.
        f0 = n_flag; q0 = codes.size();
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h2D, 1'b1, 1'b1);
        send_frame(8'h32, 1'b0, 1'b1);
        wait_cyc(5);
`ifdef PS2_BREAK_FILTER_EN
        chk("break_flags", n_flag - f0, 1);
        chk("break_code", (codes.size() > q0) ? int'(codes[q0]) : -1, 8'h32);
`else
        exp3[0] = 8'hF0; exp3[1] = 8'h2D; exp3[2] = 8'h32;
        chk("break_flags", n_flag - f0, 3);
        for (int k = 0; k < 3; k++)
            chk("break_code", (codes.size() > q0 + k) ? int'(codes[q0 + k]) : -1, int'(exp3[k]));
`endif
        chk("break_scancode", int'(scancode), 8'h32);

        // Timeout: start + 4 data bits, then silence.
        f0 = n_flag; e0 = n_err;
        send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        ps2_data = 1'b1;
        wait_cyc(TO + 10);
        chk("timeout_err", n_err - e0, 1);
        chk("timeout_flag", n_flag - f0, 0);
        send_frame(8'h34, 1'b0, 1'b1);
        wait_cyc(5);
        chk("after_timeout_flag", n_flag - f0, 1);
        chk("after_timeout_code", int'(scancode), 8'h34);

        // Glitch shorter than the filter length while idle.
        f0 = n_flag; e0 = n_err;
        ps2_clk = 1'b0;
        wait_cyc(F - 2);
        ps2_clk = 1'b1;
        wait_cyc(30);
        chk("glitch_flag", n_flag - f0, 0);
        chk("glitch_err", n_err - e0, 0);
        send_frame(8'h2D, 1'b1, 1'b1);
        wait_cyc(5);
        chk("after_glitch_flag", n_flag - f0, 1);
        chk("after_glitch_err", n_err - e0, 0);
        chk("after_glitch_code", int'(scancode), 8'h2D);

        // Reset after five data bits.
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        reset = 1'b1;
        #2;
        chk("midreset_scancode", int'(scancode), 0);
        chk("midreset_flag", int'(flag), 0);
        chk("midreset_err", int'(frame_err), 0);
        ps2_data = 1'b1;
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(5);
        f0 = n_flag; e0 = n_err;
        send_frame(8'h32, 1'b0, 1'b1);
        wait_cyc(5);
        chk("after_reset_flag", n_flag - f0, 1);
        chk("after_reset_err", n_err - e0, 0);
        chk("after_reset_code", int'(scancode), 8'h32);

        // Randomized frames against a frame-level model.
        pulse_reset();
        mcode = 8'h00;
        pend  = 1'b0;
        for (int n = 0; n < 16; n++) begin
            d = ($urandom_range(0, 5) == 0) ? 8'hF0 : 8'($urandom);
            par  = good_par(d) ^ ($urandom_range(0, 4) == 0);
            stop = !($urandom_range(0, 7) == 0);
            valid = ((($countones(d) + int'(par)) % 2) == 1) && stop;
            ef = 0; ee = 0;
            if (!valid) begin
                ee = 1;
                pend = 1'b0;
            end else begin
`ifdef PS2_BREAK_FILTER_EN
                if (pend)            pend = 1'b0;
                else if (d == 8'hF0) pend = 1'b1;
                else begin ef = 1; mcode = d; end
`else
                ef = 1; mcode = d;
`endif
            end
            f0 = n_flag; e0 = n_err;
            send_frame(d, par, stop);
            wait_cyc(3);
            chk("rand_flag", n_flag - f0, ef);
            chk("rand_err", n_err - e0, ee);
            chk("rand_code", int'(scancode), int'(mcode));
        end

        chk("flag_err_overlap", n_both, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
